pwm_duty_ramp: RTL and testbench
================================

// Module: pwm_duty_ramp
// PURPOSE
//  Upstream duty-cycle sequencer for the PWM LED stage. Produces a "breathing" triangular duty
//  value (ramp up, hold high, ramp down, hold low) that the PWM core consumes.
//  Advances only on PWM period boundaries (period_tick from the PWM core), so duty never changes mid-period.
//  A prescaler stretches the ramp over several PWM periods.
// PARAMETERS
//  DUTY_W          8    width of duty value
//  DUTY_MIN        0    lowest duty (LED dimmest); must be < DUTY_MAX
//  DUTY_MAX        255  highest duty; must be <= 2**DUTY_W-1
//  STEP            1    duty increment/decrement per step tick; >= 1
//  TICKS_PER_STEP  2    period_ticks per step tick; >= 1
//  HOLD_TICKS      25   step ticks spent in each hold state; >= 1
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous, active-low reset
//  enable      in   1       run sequencer; low forces IDLE
//  period_tick in   1       1-cycle pulse from PWM core at start of each PWM period
//  duty        out  DUTY_W  duty value for PWM comparator (registered)
//  duty_valid  out  1       1-cycle pulse: duty was (re)written this cycle
//  phase       out  3       current state encoding (debug/LED status)
// BEHAVIOUR
//  Reset: duty=DUTY_MIN, duty_valid=0, phase=IDLE, prescaler=0, hold_cnt=0. Applies immediately, mid-ramp included.
//  step_tick: prescaler counts period_ticks 0..TICKS_PER_STEP-1; pulses on the tick that wraps it to 0.
//   TICKS_PER_STEP=1 -> step_tick = period_tick, same cycle (combinational pass-through).
//  States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO. All transitions occur on step_tick, except IDLE exit and enable drop.
//  IDLE: duty=DUTY_MIN, prescaler held 0. enable=1 and period_tick=1 -> UP. No duty_valid on this transition.
//  UP   on step_tick: duty<=min(duty+STEP,DUTY_MAX). If result==DUTY_MAX -> HOLD_HI, hold_cnt<=0.
//  HOLD_HI on step_tick: duty unchanged. hold_cnt==HOLD_TICKS-1 -> DOWN, else hold_cnt++.
//  DOWN on step_tick: duty<=max(duty-STEP,DUTY_MIN). If result==DUTY_MIN -> HOLD_LO, hold_cnt<=0.
//  HOLD_LO on step_tick: mirror of HOLD_HI. Exit -> UP.
//  Arithmetic: add/sub in DUTY_W+1 bits (sub signed); clamp before writing, so no wrap-around ever occurs.
//  duty_valid=1 in the cycle after every step_tick processed in a non-IDLE state, holds included.
//   Latency: period_tick -> duty/duty_valid update = 1 clk.
//  enable low in any state: next clk -> IDLE, duty=DUTY_MIN, prescaler=0, hold_cnt=0, duty_valid=1 once
//   (only if duty actually changed).
//  enable falling in the same cycle as period_tick: enable wins, and the step is discarded.
//  period_tick while IDLE and enable=0: ignored.
//  period_tick asserted on consecutive cycles: each cycle counts as a separate tick (no edge detection).
// STRUCTURE
//  Shared package pwm_pkg:
//   - phase encoding localparams (IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4)
//   - default DUTY_W, shared by PWM_Control.
//  Sub-module pwm_tick_prescaler (period_tick in, step_tick out, sync clear input, TICKS_PER_STEP param).
//  Top: single registered FSM + hold counter + saturating duty register.
// TESTING (DUTY_W=8, MIN=0, MAX=255, STEP=64, TICKS_PER_STEP=1, HOLD_TICKS=2 unless noted)
//  1 Full cycle: enable=1, 12 period_ticks -> duty 64,128,192,255,255,255,191,127,63,0,0,0; then 64.
//     duty_valid fires on each tick.
//  2 Latency: single period_tick at cycle N -> duty and duty_valid change at N+1 only; duty_valid low at N+2.
//  3 Prescaler: TICKS_PER_STEP=3, 6 ticks from IDLE -> duty changes only on ticks 3 and 6 (64, 128).
//  4 Enable drop: mid-DOWN at duty=127, enable=0 together with period_tick -> next clk duty=0,
//     phase=IDLE, one duty_valid.
//  5 Reset mid-HOLD_HI: assert rst_n=0 asynchronously -> duty=0, phase=IDLE immediately;
//     after release, first tick -> duty=64.
//  6 Clamp: STEP=100 -> duty 100, 200, 255, hold, 155, 55, 0; never wraps.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared PWM definitions (phase encoding, default duty width).
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int unsigned c_default_duty_w = 8;
    localparam int unsigned c_phase_w        = 3;

    typedef enum logic [c_phase_w-1:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/pwm_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tick_prescaler
// Purpose  : Divides PWM period ticks into step ticks; pass-through when 1.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_tick_prescaler #(
    parameter int unsigned TICKS_PER_STEP = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic period_tick,
    output logic step_tick
);

    localparam int unsigned c_cnt_w = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICKS_PER_STEP - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    // With a single tick per step the counter is constant zero, so the
    // output reduces to a combinational copy of period_tick.
    assign w_wrap    = (r_cnt == c_last);
    assign step_tick = period_tick & w_wrap & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (period_tick) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_ramp
// Purpose  : Breathing (triangular) duty sequencer advancing on PWM periods.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W         = c_default_duty_w,
    parameter int unsigned DUTY_MIN       = 0,
    parameter int unsigned DUTY_MAX       = 255,
    parameter int unsigned STEP           = 1,
    parameter int unsigned TICKS_PER_STEP = 2,
    parameter int unsigned HOLD_TICKS     = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 period_tick,
    output logic [DUTY_W-1:0]    duty,
    output logic                 duty_valid,
    output logic [c_phase_w-1:0] phase
);

    localparam int unsigned        c_hold_w    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_TICKS - 1);
    localparam logic [DUTY_W-1:0]  c_min       = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0]  c_max       = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W:0]    c_min_x     = (DUTY_W + 1)'(DUTY_MIN);
    localparam logic [DUTY_W:0]    c_max_x     = (DUTY_W + 1)'(DUTY_MAX);
    localparam logic [DUTY_W:0]    c_step_x    = (DUTY_W + 1)'(STEP);

    phase_e                r_phase;
    logic [DUTY_W-1:0]     r_duty;
    logic                  r_valid;
    logic [c_hold_w-1:0]   r_hold;

    logic                  w_step;
    phase_e                w_eff;
    logic [DUTY_W:0]       w_sum;
    logic signed [DUTY_W:0] w_diff;
    logic [DUTY_W-1:0]     w_duty_up;
    logic [DUTY_W-1:0]     w_duty_dn;

    pwm_tick_prescaler #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (~enable),
        .period_tick (period_tick),
        .step_tick   (w_step)
    );

    // One extra bit of headroom lets the clamp see the overflow/underflow.
    assign w_sum     = {1'b0, r_duty} + c_step_x;
    assign w_diff    = $signed({1'b0, r_duty}) - $signed(c_step_x);
    assign w_duty_up = (w_sum >= c_max_x) ? c_max : w_sum[DUTY_W-1:0];
    assign w_duty_dn = (w_diff <= $signed(c_min_x)) ? c_min : w_diff[DUTY_W-1:0];

    // The tick that wakes the sequencer from IDLE is already a ramp-up tick.
    assign w_eff = (r_phase == IDLE && period_tick) ? UP : r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= IDLE;
            r_duty  <= c_min;
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else if (!enable) begin
            r_phase <= IDLE;
            r_duty  <= c_min;
            r_hold  <= '0;
            r_valid <= (r_duty != c_min);
        end else begin
            r_valid <= 1'b0;
            r_phase <= w_eff;
            if (w_step) begin
                r_valid <= 1'b1;
                case (w_eff)
                    UP: begin
                        r_duty <= w_duty_up;
                        if (w_duty_up == c_max) begin
                            r_phase <= HOLD_HI;
                            r_hold  <= '0;
                        end
                    end
                    HOLD_HI: begin
                        if (r_hold == c_hold_last) begin
                            r_phase <= DOWN;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    DOWN: begin
                        r_duty <= w_duty_dn;
                        if (w_duty_dn == c_min) begin
                            r_phase <= HOLD_LO;
                            r_hold  <= '0;
                        end
                    end
                    HOLD_LO: begin
                        if (r_hold == c_hold_last) begin
                            r_phase <= UP;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign duty       = r_duty;
    assign duty_valid = r_valid;
    assign phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_ramp
// Purpose  : Randomized self-checking bench for pwm_duty_ramp (3 configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramp;

    localparam int c_n    = 3;
    localparam int c_min  = 0;
    localparam int c_max  = 255;
    localparam int c_hold = 2;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       period_tick;
    logic [7:0] duty  [c_n];
    logic       valid [c_n];
    logic [2:0] phase [c_n];

    int cfg_step [c_n] = '{64, 64, 100};
    int cfg_tps  [c_n] = '{1, 3, 1};

    // Expected waveform: duty and phase after the k-th step of one breath.
    int wave_d [c_n][64];
    int wave_p [c_n][64];
    int wave_l [c_n];

    int m_duty  [c_n];
    int m_phase [c_n];
    int m_valid [c_n];
    int m_ticks [c_n];

    int n_checks = 0;
    int n_fail   = 0;

    pwm_duty_ramp #(.DUTY_W(8), .DUTY_MIN(0), .DUTY_MAX(255), .STEP(64),
                    .TICKS_PER_STEP(1), .HOLD_TICKS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period_tick(period_tick),
        .duty(duty[0]), .duty_valid(valid[0]), .phase(phase[0]));

    pwm_duty_ramp #(.DUTY_W(8), .DUTY_MIN(0), .DUTY_MAX(255), .STEP(64),
                    .TICKS_PER_STEP(3), .HOLD_TICKS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period_tick(period_tick),
        .duty(duty[1]), .duty_valid(valid[1]), .phase(phase[1]));

    pwm_duty_ramp #(.DUTY_W(8), .DUTY_MIN(0), .DUTY_MAX(255), .STEP(100),
                    .TICKS_PER_STEP(1), .HOLD_TICKS(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period_tick(period_tick),
        .duty(duty[2]), .duty_valid(valid[2]), .phase(phase[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic build_wave(input int i);
        int v;
        int n;
        v = c_min;
        n = 0;
        do begin
            v = (v + cfg_step[i] > c_max) ? c_max : v + cfg_step[i];
            wave_d[i][n] = v;
            wave_p[i][n] = (v == c_max) ? 2 : 1;
            n++;
        end while (v != c_max);
        for (int h = 0; h < c_hold; h++) begin
            wave_d[i][n] = c_max;
            wave_p[i][n] = (h == c_hold - 1) ? 3 : 2;
            n++;
        end
        do begin
            v = (v - cfg_step[i] < c_min) ? c_min : v - cfg_step[i];
            wave_d[i][n] = v;
            wave_p[i][n] = (v == c_min) ? 4 : 3;
            n++;
        end while (v != c_min);
        for (int h = 0; h < c_hold; h++) begin
            wave_d[i][n] = c_min;
            wave_p[i][n] = (h == c_hold - 1) ? 1 : 4;
            n++;
        end
        wave_l[i] = n;
    endtask

    task automatic model_reset();
        for (int i = 0; i < c_n; i++) begin
            m_duty[i]  = c_min;
            m_phase[i] = 0;
            m_valid[i] = 0;
            m_ticks[i] = 0;
        end
    endtask

    // Outputs expected after one clock edge with the given inputs.
    task automatic model_step(input bit en, input bit tick);
        int k;
        for (int i = 0; i < c_n; i++) begin
            if (!en) begin
                m_valid[i] = (m_duty[i] != c_min);
                m_duty[i]  = c_min;
                m_phase[i] = 0;
                m_ticks[i] = 0;
            end else begin
                m_valid[i] = 0;
                if (tick) begin
                    m_ticks[i]++;
                    if (m_phase[i] == 0) m_phase[i] = 1;
                    if (m_ticks[i] % cfg_tps[i] == 0) begin
                        k = m_ticks[i] / cfg_tps[i];
                        m_duty[i]  = wave_d[i][(k - 1) % wave_l[i]];
                        m_phase[i] = wave_p[i][(k - 1) % wave_l[i]];
                        m_valid[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < c_n; i++) begin
            chk($sformatf("%s duty[%0d]", tag, i), int'(duty[i]), m_duty[i]);
            chk($sformatf("%s valid[%0d]", tag, i), int'(valid[i]), m_valid[i]);
            chk($sformatf("%s phase[%0d]", tag, i), int'(phase[i]), m_phase[i]);
        end
    endtask

    task automatic cycle(input bit en, input bit tick, input string tag);
        @(negedge clk);
        enable      = en;
        period_tick = tick;
        model_step(en, tick);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset();
        @(negedge clk);
        period_tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        period_tick = 1'b0;
        for (int i = 0; i < c_n; i++) build_wave(i);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ticks through a full breath and into the next ramp.
        for (int c = 0; c < 13; c++) cycle(1'b1, 1'b1, "full");
        cycle(1'b1, 1'b0, "idle_gap");
        cycle(1'b1, 1'b0, "idle_gap");
        // Enable drop coinciding with a tick, then a tick while disabled.
        cycle(1'b0, 1'b1, "drop");
        cycle(1'b0, 1'b1, "off_tick");
        cycle(1'b1, 1'b0, "re_en");

        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 249) != 0, $urandom_range(0, 1) == 1, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
